// File: rtl/ntt_coef_buffer_if.sv
// ntt_coef_buffer_if: input/output coefficient streams and NTT core port bundle for ntt_coef_buffer.
interface ntt_coef_buffer_if #(
  parameter int LOGQ  = 64,
  parameter int ADDRW = 10
);
  logic             intt_in, s_valid, s_ready;
  logic [LOGQ-1:0]  s_data;
  logic             ntt_start, ntt_intt;
  logic [ADDRW-1:0] ntt_read_address, ntt_write_address;
  logic [LOGQ-1:0]  ntt_din_0, ntt_din_1, ntt_dout_0, ntt_dout_1;
  logic             ntt_wea, ntt_finish;
  logic             m_valid, m_ready, m_last, busy;
  logic [LOGQ-1:0]  m_data;
  modport slave (
    input  intt_in, s_valid, s_data, ntt_read_address, ntt_write_address, ntt_wea,
           ntt_dout_0, ntt_dout_1, ntt_finish, m_ready,
    output s_ready, ntt_start, ntt_intt, ntt_din_0, ntt_din_1, m_valid, m_data, m_last, busy
  );
  modport master (
    output intt_in, s_valid, s_data, ntt_read_address, ntt_write_address, ntt_wea,
           ntt_dout_0, ntt_dout_1, ntt_finish, m_ready,
    input  s_ready, ntt_start, ntt_intt, ntt_din_0, ntt_din_1, m_valid, m_data, m_last, busy
  );
endinterface

// File: rtl/ntt_coef_buffer.sv
// ntt_coef_buffer: natural-order load, paired (addr, addr+N/2) core access, natural-order unload.
module ntt_coef_buffer #(
  parameter int LOGQ       = 64,
  parameter int LOGN       = 4,
  parameter int DELAY_BRAM = 1,
  parameter int ADDRW      = ((LOGN < 9) ? 9 : LOGN) + 1
) (
  input logic clk,
  input logic rst,
  ntt_coef_buffer_if.slave bus
);
  localparam int N     = 2 ** LOGN;
  localparam int H     = N / 2;
  localparam int RW    = LOGN - 1;
  localparam int PW    = DELAY_BRAM * LOGQ;
  localparam int DEPTH = DELAY_BRAM + 1;
  localparam int FCW   = $clog2(DEPTH + 1);
  localparam int FS    = 2 ** FCW;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, UNLOAD} state_t;
  state_t                r_state;
  logic [LOGQ-1:0]       r_lo [H];
  logic [LOGQ-1:0]       r_hi [H];
  logic [LOGN-1:0]       r_cnt;
  logic [LOGN:0]         r_issue;
  logic                  r_s_ready, r_start, r_intt, r_m_valid, r_m_last, r_busy;
  logic [LOGQ-1:0]       r_m_data;
  logic [PW-1:0]         r_din0, r_din1, r_pd;
  logic [DELAY_BRAM-1:0] r_pv, r_pl;
  logic [LOGQ:0]         r_fd [FS];
  logic [FCW-1:0]        r_fc;
  logic                  w_s_hs, w_m_hs, w_issue, w_arr, w_take, w_pop, w_push, w_load;
  logic [FCW-1:0]        w_used, w_widx;
  logic [LOGQ:0]         w_arr_item, w_next;
  logic [LOGQ-1:0]       w_rdata;
  logic [RW-1:0]         w_rrow, w_wrow;
  // Unload reads are only issued while pipeline plus skid FIFO can absorb them under a full stall.
  always_comb begin
    w_s_hs = bus.s_valid && r_s_ready;
    w_m_hs = r_m_valid && bus.m_ready;
    w_used = r_fc;
    for (int i = 0; i < DELAY_BRAM; i++) w_used = w_used + FCW'(r_pv[i]);
    w_issue = r_state == UNLOAD && !r_issue[LOGN] && w_used < FCW'(DEPTH);
    w_arr = r_pv[DELAY_BRAM-1];
    w_arr_item = {r_pl[DELAY_BRAM-1], r_pd[PW-1 -: LOGQ]};
    w_take = !r_m_valid || bus.m_ready;
    w_pop = w_take && r_fc != '0;
    w_load = w_take && (r_fc != '0 || w_arr);
    w_push = w_arr && (!w_take || r_fc != '0);
    w_next = r_fc != '0 ? r_fd[0] : w_arr_item;
    w_widx = r_fc - FCW'(w_pop);
    w_rdata = r_issue[RW] ? r_hi[r_issue[RW-1:0]] : r_lo[r_issue[RW-1:0]];
    w_rrow = bus.ntt_read_address[RW-1:0];
    w_wrow = bus.ntt_write_address[RW-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_issue   <= '0;
      r_s_ready <= 1'b0;
      r_start   <= 1'b0;
      r_intt    <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_data  <= '0;
      r_busy    <= 1'b0;
      r_pv      <= '0;
      r_pl      <= '0;
      r_fc      <= '0;
    end else begin
      if (w_issue) r_issue <= r_issue + (LOGN+1)'(1);
      unique case (r_state)
        IDLE: begin
          r_s_ready <= 1'b1;
          if (w_s_hs) begin
            r_state <= LOAD;
            r_intt  <= bus.intt_in;
            r_cnt   <= LOGN'(1);
            r_busy  <= 1'b1;
          end
        end
        LOAD: if (w_s_hs) begin
          r_cnt <= r_cnt + LOGN'(1);
          if (r_cnt == LOGN'(N-1)) begin
            r_state   <= RUN;
            r_s_ready <= 1'b0;
            r_start   <= 1'b1;
          end
        end
        RUN: if (bus.ntt_finish) begin
          r_state <= UNLOAD;
          r_start <= 1'b0;
        end
        UNLOAD: if (w_m_hs && r_m_last) begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_s_ready <= 1'b1;
          r_issue   <= '0;
        end
      endcase
      r_pv <= DELAY_BRAM'({r_pv, w_issue});
      r_pl <= DELAY_BRAM'({r_pl, r_issue[LOGN-1:0] == LOGN'(N-1)});
      if (w_take) begin
        r_m_valid <= w_load;
        r_m_last  <= w_load && w_next[LOGQ];
        if (w_load) r_m_data <= w_next[LOGQ-1:0];
      end
      r_fc <= r_fc - FCW'(w_pop) + FCW'(w_push);
    end
  end
  always_ff @(posedge clk) begin
    r_din0 <= rst ? '0 : PW'({r_din0, r_lo[w_rrow]});
    r_din1 <= rst ? '0 : PW'({r_din1, r_hi[w_rrow]});
    r_pd   <= PW'({r_pd, w_rdata});
    if (!rst && w_s_hs && r_cnt[RW]) r_hi[r_cnt[RW-1:0]] <= bus.s_data;
    if (!rst && w_s_hs && !r_cnt[RW]) r_lo[r_cnt[RW-1:0]] <= bus.s_data;
    if (!rst && r_state == RUN && bus.ntt_wea) begin
      r_lo[w_wrow] <= bus.ntt_dout_0;
      r_hi[w_wrow] <= bus.ntt_dout_1;
    end
    for (int i = 0; i < FS-1; i++) if (w_pop) r_fd[i] <= r_fd[i+1];
    if (w_push) r_fd[w_widx] <= w_arr_item;
  end
  assign bus.s_ready   = r_s_ready;
  assign bus.ntt_start = r_start;
  assign bus.ntt_intt  = r_intt;
  assign bus.ntt_din_0 = r_din0[PW-1 -: LOGQ];
  assign bus.ntt_din_1 = r_din1[PW-1 -: LOGQ];
  assign bus.m_valid   = r_m_valid;
  assign bus.m_data    = r_m_data;
  assign bus.m_last    = r_m_last;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_ntt_coef_buffer.sv
// tb_ntt_coef_buffer: read-vector table, directed corner sequences and random transactions against a natural-order model.
module tb_ntt_coef_buffer;
  localparam int LOGQ = 64, LOGN = 4, D = 1, N = 16, H = 8, ADDRW = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [LOGQ-1:0] mdl [N];
  logic exp_intt = 1'b0;
  typedef struct {
    logic [ADDRW-1:0] raddr;
    logic [LOGQ-1:0]  d0, d1;
  } rd_vec_t;
  rd_vec_t rd_tab [6];
  ntt_coef_buffer_if #(.LOGQ(LOGQ), .ADDRW(ADDRW)) bus ();
  ntt_coef_buffer #(.LOGQ(LOGQ), .LOGN(LOGN), .DELAY_BRAM(D), .ADDRW(ADDRW)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [LOGQ-1:0] act, input logic [LOGQ-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic drive_idle();
    bus.s_valid = 1'b0; bus.s_data = '0; bus.intt_in = 1'b0; bus.m_ready = 1'b0;
    bus.ntt_read_address = '0; bus.ntt_write_address = '0; bus.ntt_wea = 1'b0;
    bus.ntt_dout_0 = '0; bus.ntt_dout_1 = '0; bus.ntt_finish = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_start", bus.ntt_start, 0);
    chk("rst_intt", bus.ntt_intt, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_din0", bus.ntt_din_0, 0);
    chk("rst_din1", bus.ntt_din_1, 0);
    chk("rst_m_data", bus.m_data, 0);
    rst = 1'b0;
  endtask
  // gap_mode: 0 back-to-back, 1 idle cycle after every word, 2 random idle cycles
  task automatic load(input logic [LOGQ-1:0] w [N], input logic intt, input int gap_mode);
    for (int i = 0; i < N; i++) begin
      int n;
      n = 0;
      bus.s_valid = 1'b1;
      bus.s_data = w[i];
      bus.intt_in = (i == 0) ? intt : ~intt;
      while (!bus.s_ready && n < 50) begin
        tick();
        n++;
      end
      chk("load_ready", bus.s_ready, 1);
      tick();
      mdl[i] = w[i];
      bus.s_valid = 1'b0;
      if (i < N-1 && (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1))) begin
        chk("gap_busy", bus.busy, 1);
        tick();
      end
    end
    exp_intt = intt;
    bus.intt_in = 1'b0;
    chk("start_rise", bus.ntt_start, 1);
    chk("run_s_ready", bus.s_ready, 0);
    chk("run_busy", bus.busy, 1);
    chk("intt_latch", bus.ntt_intt, exp_intt);
  endtask
  task automatic probe(input logic [ADDRW-1:0] ra, input logic [LOGQ-1:0] e0, input logic [LOGQ-1:0] e1);
    bus.ntt_read_address = ra;
    repeat (D) tick();
    chk("din_0", bus.ntt_din_0, e0);
    chk("din_1", bus.ntt_din_1, e1);
  endtask
  task automatic core_cycle(input logic [ADDRW-1:0] wa, input logic wea,
                            input logic [LOGQ-1:0] d0, input logic [LOGQ-1:0] d1, input logic fin);
    bus.ntt_write_address = wa; bus.ntt_wea = wea;
    bus.ntt_dout_0 = d0; bus.ntt_dout_1 = d1; bus.ntt_finish = fin;
    chk("run_intt", bus.ntt_intt, exp_intt);
    chk("run_start", bus.ntt_start, 1);
    chk("run_s_ready", bus.s_ready, 0);
    tick();
    if (wea) begin
      mdl[wa % H] = d0;
      mdl[wa % H + H] = d1;
    end
    bus.ntt_wea = 1'b0;
    bus.ntt_finish = 1'b0;
  endtask
  // mode: 0 always ready, 1 ready pattern 1,0,0,1, 2 random ready
  task automatic unload(input int mode);
    int j, c, first;
    logic stalled;
    logic [LOGQ-1:0] held;
    j = 0; c = 0; first = -1; stalled = 1'b0; held = '0;
    chk("unload_start_low", bus.ntt_start, 0);
    while (j < N && c < 400) begin
      bus.m_ready = (mode == 0) || (mode == 1 && (c % 4 == 0 || c % 4 == 3)) ||
                    (mode == 2 && $urandom_range(0, 1) == 1);
      if (bus.m_valid && first < 0) first = c;
      if (stalled) begin
        chk("stall_valid", bus.m_valid, 1);
        chk("stall_data", bus.m_data, held);
      end
      if (bus.m_valid && bus.m_ready) begin
        chk("m_data", bus.m_data, mdl[j]);
        chk("m_last", bus.m_last, j == N-1);
        j++;
      end
      stalled = bus.m_valid && !bus.m_ready;
      held = bus.m_data;
      tick();
      c++;
    end
    bus.m_ready = 1'b0;
    chk("unload_count", j, N);
    chk("first_valid_lat", first, D + 1);
    chk("end_m_valid", bus.m_valid, 0);
    chk("end_m_last", bus.m_last, 0);
    chk("end_busy", bus.busy, 0);
    chk("end_s_ready", bus.s_ready, 1);
  endtask
  initial begin
    logic [LOGQ-1:0] w [N];
    rd_tab[0] = '{10'h003, 64'd4, 64'd12};
    rd_tab[1] = '{10'h000, 64'd1, 64'd9};
    rd_tab[2] = '{10'h007, 64'd8, 64'd16};
    rd_tab[3] = '{10'h203, 64'd4, 64'd12};
    rd_tab[4] = '{10'h015, 64'd6, 64'd14};
    rd_tab[5] = '{10'h3fa, 64'd3, 64'd11};
    drive_idle();
    do_reset();
    for (int i = 0; i < N; i++) w[i] = LOGQ'(i + 1);
    load(w, 1'b0, 0);
    foreach (rd_tab[i]) probe(rd_tab[i].raddr, rd_tab[i].d0, rd_tab[i].d1);
    for (int k = 0; k < H; k++) core_cycle(ADDRW'(k), 1'b1, LOGQ'(100 + k), LOGQ'(200 + k), 1'b0);
    core_cycle('0, 1'b0, '0, '0, 1'b1);
    unload(0);
    bus.ntt_write_address = '0; bus.ntt_wea = 1'b1; bus.ntt_finish = 1'b1;
    bus.ntt_dout_0 = 64'hdead; bus.ntt_dout_1 = 64'hbeef;
    tick();
    drive_idle();
    chk("stray_busy", bus.busy, 0);
    chk("stray_start", bus.ntt_start, 0);
    chk("stray_s_ready", bus.s_ready, 1);
    chk("stray_m_valid", bus.m_valid, 0);
    probe('0, mdl[0], mdl[H]);
    for (int i = 0; i < N; i++) w[i] = 64'hA000 + LOGQ'(i);
    load(w, 1'b1, 1);
    probe(10'h005, mdl[5], mdl[13]);
    for (int k = 0; k < H; k++)
      core_cycle(ADDRW'(H - 1 - k), 1'b1, 64'h5000 + LOGQ'(k), 64'h6000 + LOGQ'(k), k == H - 1);
    unload(1);
    for (int i = 0; i < N; i++) w[i] = 64'hC000 + LOGQ'(i);
    load(w, 1'b1, 0);
    core_cycle(ADDRW'(2), 1'b1, 64'h77, 64'h88, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_start", bus.ntt_start, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_m_valid", bus.m_valid, 0);
    chk("midrst_intt", bus.ntt_intt, 0);
    for (int i = 0; i < N; i++) w[i] = 64'hE000 + LOGQ'(i * 3);
    load(w, 1'b0, 0);
    core_cycle('0, 1'b0, '0, '0, 1'b1);
    unload(0);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) w[i] = {$urandom, $urandom};
      load(w, 1'($urandom_range(0, 1)), 2);
      for (int k = 0; k < 12; k++) begin
        logic [ADDRW-1:0] ra;
        ra = ADDRW'($urandom);
        if (k % 4 == 0) probe(ra, mdl[ra % H], mdl[ra % H + H]);
        core_cycle(ADDRW'($urandom), 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      end
      core_cycle(ADDRW'($urandom), 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
      unload(2);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ntt_coef_buffer.md
Name: ntt_coef_buffer

Overview:
- Coefficient buffer placed directly upstream and downstream of ntt_memory_wrapper.
- Accepts N coefficients in natural order over a valid/ready stream and serves them to the NTT core as the pair (addr, addr+N/2).
- Captures the pair results that the NTT core writes back, then streams the N results out in natural order.
- Also generates the core's start and intt controls.

Parameters:
- LOGQ, 64, coefficient bit-width.
- LOGN, 4, log2 of polynomial size; N=2**LOGN.
- DELAY_BRAM, 1, read latency (1 or 2) from ntt_read_address to ntt_din_0/1; must equal the core's DELAY_BRAM.
- ADDRW, ((LOGN<9)?9:LOGN)+1, width of core address ports.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- intt_in  in  1  mode for the next transform; latched with the first accepted input word.
- s_valid  in  1  input coefficient valid
- s_ready  out  1  buffer can accept an input coefficient
- s_data  in  LOGQ  input coefficient
- ntt_start  out  1  start to the NTT core
- ntt_intt  out  1  latched mode to the core
- ntt_read_address  in  ADDRW  core read address
- ntt_din_0  out  LOGQ  coefficient[addr]
- ntt_din_1  out  LOGQ  coefficient[addr+N/2]
- ntt_write_address  in  ADDRW  core write address
- ntt_wea  in  1  core write enable
- ntt_dout_0  in  LOGQ  result for [waddr]
- ntt_dout_1  in  LOGQ  result for [waddr+N/2]
- ntt_finish  in  1  core done
- m_valid  out  1  output coefficient valid
- m_ready  in  1  downstream accepts the output coefficient
- m_data  out  LOGQ  output coefficient
- m_last  out  1  high with coefficient N-1
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Storage: two banks LO and HI, each N/2 x LOGQ.
  - Index i maps to bank i[LOGN-1], row i[LOGN-2:0].
  - Core addresses use only bits [LOGN-2:0]; upper address bits are ignored.
- Reset: state=IDLE; s_ready, ntt_start, ntt_intt, m_valid, m_last, busy all 0; ntt_din_0/1 and m_data all 0; counters 0.
  - Memory contents are not cleared.
  - Reset asserted in any state aborts immediately; the next cycle is IDLE.
- FSM IDLE:
  - s_ready=1.
  - On an s_valid&&s_ready handshake: write word 0, latch intt_in into ntt_intt, cnt=1, go to LOAD.
- FSM LOAD:
  - s_ready=1. Each handshake writes word cnt, then cnt++.
  - The handshake of word N-1 moves to RUN on the next edge.
  - Gaps (s_valid=0) are allowed and hold the state.
- FSM RUN:
  - s_ready=0; ntt_start=1 from the first RUN cycle until ntt_finish is sampled high.
  - ntt_din_0/1 = LO/HI[raddr] delayed exactly DELAY_BRAM cycles; registered every cycle in all states.
  - When ntt_wea=1: LO[waddr]<=ntt_dout_0 and HI[waddr]<=ntt_dout_1.
  - A write in the same cycle that ntt_finish is sampled is still committed.
  - ntt_finish=1 clears ntt_start on the next edge and moves to UNLOAD.
- ntt_finish and ntt_wea outside RUN are ignored; no memory write occurs.
- FSM UNLOAD:
  - Read index j=0..N-1 through a prefetch pipeline plus a skid register.
  - The first m_valid rises exactly DELAY_BRAM+1 cycles after UNLOAD entry.
  - With m_ready held high, one word is delivered per cycle.
  - While m_valid&&!m_ready, m_data and m_last are held stable.
  - m_last=1 only with j=N-1. Its handshake returns the FSM to IDLE next cycle (m_valid=0, busy=0).
- Input words offered while in RUN/UNLOAD are not accepted (s_ready=0) and must be held by the source.
- ntt_intt stays stable from latch until the next IDLE->LOAD transition.

Test Plan:
- Forward transform: load s_data=i+1 for i=0..15 with intt_in=0 -> ntt_start rises on the cycle after word 15. With raddr=3 and DELAY_BRAM=1, ntt_din_0=4 and ntt_din_1=12 one cycle later. ntt_intt=0.
- Write-back plus unload: the core model writes waddr=k with dout_0=100+k, dout_1=200+k for k=0..7, then finish. Stream out with m_ready=1 -> m_data = 100..107, then 200..207. m_last is high only on 207; busy falls after it.
- Backpressure: m_ready toggles 1,0,0,1 during unload -> no word is lost or duplicated and m_data is constant while stalled. Total of 16 handshakes.
- Input gaps and mode: s_valid is low every other cycle and intt_in=1 is on word 0 only -> 16 words are stored correctly, ntt_intt=1 throughout RUN, and s_ready=0 in RUN.
- Late write plus stray finish: ntt_wea=1 in the same cycle as ntt_finish is committed and read back correctly. ntt_finish pulsed in IDLE causes no state change.
- Reset mid-RUN: assert rst during RUN -> the next cycle is IDLE with ntt_start=0 and busy=0. A fresh 16-word load then completes normally.
